pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32: PC, target and CSR datapath width in bits.
REQ-002 Parameter RESET_VECTOR, default 0: PC value loaded on reset.
REQ-003 Parameter MTVEC_RESET, default 'h100: trap vector value loaded on reset.
REQ-004 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n  in  1: reset, asynchronous, active-low.
REQ-006 Port stall  in  1: hold PC (pipeline stall).
REQ-007 Port PCsrc  in  2: next-PC select; 00 sequential, 01 PC+ImmOp, 10 ALUResult, 11 sequential.
REQ-008 Port ImmOp  in  WIDTH: branch/JAL offset.
REQ-009 Port ALUResult  in  WIDTH: JALR target.
REQ-010 Port trap  in  1: exception/interrupt request, one-cycle pulse.
REQ-011 Port mret  in  1: return-from-trap request, one-cycle pulse.
REQ-012 Port mtvec_we  in  1: write enable for trap vector register.
REQ-013 Port mtvec_wdata  in  WIDTH: new trap vector value.
REQ-014 Port PC  out  WIDTH: current fetch address.
REQ-015 Port PCPlus4  out  WIDTH: PC+4, combinational from PC.
REQ-016 Port mepc  out  WIDTH: PC saved at last trap.
REQ-017 Port mtvec  out  WIDTH: current trap vector.
REQ-018 Port in_trap  out  1: high while executing a trap handler.
REQ-019 Port pc_valid  out  1: PC is a valid fetch address.

Function
REQ-020 Next-PC priority, highest first: trap, mret, stall, PCsrc.
REQ-021 trap=1: PC <= mtvec, mepc <= current PC, in_trap <= 1; applies regardless of stall.
REQ-022 mret=1 (trap=0): PC <= mepc, in_trap <= 0; applies regardless of stall.
REQ-023 trap and mret in same cycle: trap taken, mret ignored, in_trap stays 1.
REQ-024 stall=1 with no trap/mret: PC, mepc and in_trap hold.
REQ-025 PCsrc=00 or 11: PC <= PC+4; 01: PC <= PC+ImmOp; 10: PC <= {ALUResult[WIDTH-1:1],1'b0}.
REQ-026 All PC arithmetic modulo 2^WIDTH; wrap-around (e.g. all-ones-3 + 4 -> 0) without error.
REQ-027 mtvec_we=1: mtvec <= {mtvec_wdata[WIDTH-1:2],2'b00}; independent of stall.
REQ-028 mtvec write coincident with trap: trap uses old mtvec; new value visible next cycle.
REQ-029 Nested trap (trap while in_trap=1): mepc overwritten with current PC.
REQ-030 mret while in_trap=0: PC <= mepc anyway; in_trap stays 0.
REQ-031 Latency: every selected update visible on PC one cycle after the sampling edge; no combinational path from inputs to PC, mepc, mtvec, in_trap, pc_valid.
REQ-032 pc_valid rises on the first rising clk edge after rst_n deasserts and stays 1 until next reset.
REQ-033 While pc_valid=0 (first post-reset edge), PC holds RESET_VECTOR; trap, mret and PCsrc are ignored.

Reset
REQ-034 rst_n=0 immediately, without clock: PC=RESET_VECTOR, mepc=0, mtvec=MTVEC_RESET, in_trap=0, pc_valid=0.
REQ-035 Reset mid-operation (stall, trap or handler active) aborts all state to REQ-034 values.
REQ-036 Reset deassertion takes effect on the next rising clk edge; no update on the deasserting edge itself.

Verification
REQ-037 Release reset, PCsrc=00 for 4 cycles -> pc_valid 0->1; PC 0,0,4,8,C.
REQ-038 PC=0x20, PCsrc=01, ImmOp=0xFFFFFFF0 -> PC=0x10; PCsrc=10, ALUResult=0x45 -> PC=0x44.
REQ-039 PC=0x30, stall=1 with PCsrc=01 for 3 cycles -> PC stays 0x30; stall=1 with trap=1 -> PC=0x100, mepc=0x30, in_trap=1.
REQ-040 mtvec_we=1, wdata=0x203 same cycle as trap at PC=0x8 -> PC=0x100; next trap at PC=0x104 -> PC=0x200, mepc=0x104; mret -> PC=0x104, in_trap=0.
REQ-041 trap and mret same cycle at PC=0x50 -> PC=mtvec, mepc=0x50, in_trap=1; PC=0xFFFFFFFC, PCsrc=00 -> PC=0.
REQ-042 Assert rst_n=0 mid-handler between clock edges -> outputs take REQ-034 values before next edge.

Source files
------------

// File: rtl/pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit_if
// Description : Control, target and CSR bundle between the pipeline and the
//               program-counter unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_unit_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic [1:0]       PCsrc;
  logic [WIDTH-1:0] ImmOp;
  logic [WIDTH-1:0] ALUResult;
  logic             trap;
  logic             mret;
  logic             mtvec_we;
  logic [WIDTH-1:0] mtvec_wdata;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] PCPlus4;
  logic [WIDTH-1:0] mepc;
  logic [WIDTH-1:0] mtvec;
  logic             in_trap;
  logic             pc_valid;

  // Pipeline side: drives requests, observes the PC state
  modport master (
    output stall, PCsrc, ImmOp, ALUResult, trap, mret, mtvec_we, mtvec_wdata,
    input  PC, PCPlus4, mepc, mtvec, in_trap, pc_valid
  );

  // PC unit side
  modport slave (
    input  stall, PCsrc, ImmOp, ALUResult, trap, mret, mtvec_we, mtvec_wdata,
    output PC, PCPlus4, mepc, mtvec, in_trap, pc_valid
  );
endinterface
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Program counter with sequential/branch/jump selection, stall,
//               trap entry (mepc/mtvec) and trap return.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] MTVEC_RESET  = WIDTH'('h100)
) (
  input  wire          clk,
  input  wire          rst_n,
  pc_unit_if.slave     bus
);

  localparam logic [1:0] c_SRC_SEQ  = 2'b00;
  localparam logic [1:0] c_SRC_IMM  = 2'b01;
  localparam logic [1:0] c_SRC_ALU  = 2'b10;
  localparam logic [1:0] c_SRC_SEQ2 = 2'b11;

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_mepc;
  logic [WIDTH-1:0] r_mtvec;
  logic             r_in_trap;
  logic             r_pc_valid;

  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_pc_next;
  logic             w_unused_bits;

  // Low bits discarded by alignment rules are intentionally ignored
  assign w_unused_bits = ^{bus.ALUResult[0], bus.mtvec_wdata[1:0]};

  assign w_pc_plus4 = r_pc + WIDTH'(4);

  // Normal-flow next PC from the PCsrc selector (wraps modulo 2^WIDTH)
  always_comb begin
    w_pc_next = w_pc_plus4;
    case (bus.PCsrc)
      c_SRC_SEQ:  w_pc_next = w_pc_plus4;
      c_SRC_IMM:  w_pc_next = r_pc + bus.ImmOp;
      c_SRC_ALU:  w_pc_next = {bus.ALUResult[WIDTH-1:1], 1'b0};
      c_SRC_SEQ2: w_pc_next = w_pc_plus4;
      default:    w_pc_next = w_pc_plus4;
    endcase
  end

  // pc_valid goes high on the first edge after reset release and stays high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_valid <= 1'b0;
    end else begin
      r_pc_valid <= 1'b1;
    end
  end

  // PC, mepc and in_trap: trap > mret > stall > PCsrc, frozen until pc_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_VECTOR;
      r_mepc    <= '0;
      r_in_trap <= 1'b0;
    end else if (r_pc_valid) begin
      if (bus.trap) begin
        r_pc      <= r_mtvec;
        r_mepc    <= r_pc;
        r_in_trap <= 1'b1;
      end else if (bus.mret) begin
        r_pc      <= r_mepc;
        r_in_trap <= 1'b0;
      end else if (!bus.stall) begin
        r_pc      <= w_pc_next;
      end
    end
  end

  // Trap vector register; a coincident trap still sees the old value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtvec <= MTVEC_RESET;
    end else if (bus.mtvec_we) begin
      r_mtvec <= {bus.mtvec_wdata[WIDTH-1:2], 2'b00};
    end
  end

  assign bus.PC       = r_pc;
  assign bus.PCPlus4  = w_pc_plus4;
  assign bus.mepc     = r_mepc;
  assign bus.mtvec    = r_mtvec;
  assign bus.in_trap  = r_in_trap;
  assign bus.pc_valid = r_pc_valid;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Self-checking bench for pc_unit: directed scenarios plus a
//               randomized run against an architectural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  // Reference model state
  logic [31:0] m_pc, m_mepc, m_mtvec;
  logic        m_in_trap, m_valid;

  pc_unit_if #(.WIDTH(WIDTH)) bus ();

  pc_unit #(
    .WIDTH       (WIDTH),
    .RESET_VECTOR(32'h0),
    .MTVEC_RESET (32'h100)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc      = 32'h0;
    m_mepc    = 32'h0;
    m_mtvec   = 32'h100;
    m_in_trap = 1'b0;
    m_valid   = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.stall       = 1'b0;
    bus.PCsrc       = 2'b00;
    bus.ImmOp       = '0;
    bus.ALUResult   = '0;
    bus.trap        = 1'b0;
    bus.mret        = 1'b0;
    bus.mtvec_we    = 1'b0;
    bus.mtvec_wdata = '0;
  endtask

  // One clock: the model applies the architectural rules to the inputs
  // present at the edge, then outputs are sampled 1 time unit later.
  task automatic tick();
    logic [31:0] old_mtvec;
    @(posedge clk);
    if (rst_n) begin
      old_mtvec = m_mtvec;
      if (bus.mtvec_we) m_mtvec = bus.mtvec_wdata & 32'hFFFF_FFFC;
      if (!m_valid) begin
        m_valid = 1'b1;
      end else if (bus.trap) begin
        m_mepc    = m_pc;
        m_pc      = old_mtvec;
        m_in_trap = 1'b1;
      end else if (bus.mret) begin
        m_pc      = m_mepc;
        m_in_trap = 1'b0;
      end else if (!bus.stall) begin
        if (bus.PCsrc == 2'b01)      m_pc = m_pc + bus.ImmOp;
        else if (bus.PCsrc == 2'b10) m_pc = bus.ALUResult & 32'hFFFF_FFFE;
        else                         m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic goto_pc(input logic [31:0] target);
    idle_inputs();
    bus.PCsrc     = 2'b10;
    bus.ALUResult = target;
    tick();
    idle_inputs();
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (bus.PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", bus.PC, 32'h0); end
    n_checks++;
    if (bus.mtvec !== 32'h100) begin n_fail++; $display("FAIL reset_mtvec got=%h exp=%h", bus.mtvec, 32'h100); end
    n_checks++;
    if (bus.mepc !== 32'h0) begin n_fail++; $display("FAIL reset_mepc got=%h exp=%h", bus.mepc, 32'h0); end
    n_checks++;
    if (bus.in_trap !== 1'b0) begin n_fail++; $display("FAIL reset_in_trap got=%b exp=0", bus.in_trap); end
    n_checks++;
    if (bus.pc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pc_valid got=%b exp=0", bus.pc_valid); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'h0; exp_seq[1] = 32'h4; exp_seq[2] = 32'h8; exp_seq[3] = 32'hC;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (bus.PC !== exp_seq[i]) begin n_fail++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus.PC, exp_seq[i]); end
      n_checks++;
      if (bus.pc_valid !== 1'b1) begin n_fail++; $display("FAIL seq_pc_valid[%0d] got=%b exp=1", i, bus.pc_valid); end
    end
    n_checks++;
    if (bus.PCPlus4 !== 32'h10) begin n_fail++; $display("FAIL seq_pcplus4 got=%h exp=%h", bus.PCPlus4, 32'h10); end
  endtask

  task automatic test_branch();
    goto_pc(32'h20);
    bus.PCsrc = 2'b01;
    bus.ImmOp = 32'hFFFF_FFF0;
    tick();
    n_checks++;
    if (bus.PC !== 32'h10) begin n_fail++; $display("FAIL branch_pc got=%h exp=%h", bus.PC, 32'h10); end
    bus.PCsrc     = 2'b10;
    bus.ALUResult = 32'h45;
    tick();
    n_checks++;
    if (bus.PC !== 32'h44) begin n_fail++; $display("FAIL jalr_pc got=%h exp=%h", bus.PC, 32'h44); end
    bus.PCsrc = 2'b11;
    tick();
    n_checks++;
    if (bus.PC !== 32'h48) begin n_fail++; $display("FAIL src11_pc got=%h exp=%h", bus.PC, 32'h48); end
    idle_inputs();
  endtask

  task automatic test_stall_trap();
    goto_pc(32'h30);
    bus.stall = 1'b1;
    bus.PCsrc = 2'b01;
    bus.ImmOp = 32'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.PC !== 32'h30) begin n_fail++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, bus.PC, 32'h30); end
    end
    bus.trap = 1'b1;
    tick();
    n_checks++;
    if (bus.PC !== 32'h100) begin n_fail++; $display("FAIL stall_trap_pc got=%h exp=%h", bus.PC, 32'h100); end
    n_checks++;
    if (bus.mepc !== 32'h30) begin n_fail++; $display("FAIL stall_trap_mepc got=%h exp=%h", bus.mepc, 32'h30); end
    n_checks++;
    if (bus.in_trap !== 1'b1) begin n_fail++; $display("FAIL stall_trap_in_trap got=%b exp=1", bus.in_trap); end
    bus.trap = 1'b0;
    bus.mret = 1'b1;
    tick();
    n_checks++;
    if (bus.PC !== 32'h30) begin n_fail++; $display("FAIL stall_mret_pc got=%h exp=%h", bus.PC, 32'h30); end
    n_checks++;
    if (bus.in_trap !== 1'b0) begin n_fail++; $display("FAIL stall_mret_in_trap got=%b exp=0", bus.in_trap); end
    idle_inputs();
  endtask

  task automatic test_mtvec();
    goto_pc(32'h8);
    bus.trap        = 1'b1;
    bus.mtvec_we    = 1'b1;
    bus.mtvec_wdata = 32'h203;
    tick();
    idle_inputs();
    n_checks++;
    if (bus.PC !== 32'h100) begin n_fail++; $display("FAIL mtvec_old_pc got=%h exp=%h", bus.PC, 32'h100); end
    n_checks++;
    if (bus.mtvec !== 32'h200) begin n_fail++; $display("FAIL mtvec_written got=%h exp=%h", bus.mtvec, 32'h200); end
    tick();
    n_checks++;
    if (bus.PC !== 32'h104) begin n_fail++; $display("FAIL mtvec_handler_pc got=%h exp=%h", bus.PC, 32'h104); end
    bus.trap = 1'b1;
    tick();
    n_checks++;
    if (bus.PC !== 32'h200) begin n_fail++; $display("FAIL nested_trap_pc got=%h exp=%h", bus.PC, 32'h200); end
    n_checks++;
    if (bus.mepc !== 32'h104) begin n_fail++; $display("FAIL nested_trap_mepc got=%h exp=%h", bus.mepc, 32'h104); end
    bus.trap = 1'b0;
    bus.mret = 1'b1;
    tick();
    n_checks++;
    if (bus.PC !== 32'h104) begin n_fail++; $display("FAIL nested_mret_pc got=%h exp=%h", bus.PC, 32'h104); end
    n_checks++;
    if (bus.in_trap !== 1'b0) begin n_fail++; $display("FAIL nested_mret_in_trap got=%b exp=0", bus.in_trap); end
    idle_inputs();
  endtask

  task automatic test_trap_mret_wrap();
    goto_pc(32'h50);
    bus.trap = 1'b1;
    bus.mret = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (bus.PC !== 32'h200) begin n_fail++; $display("FAIL both_pc got=%h exp=%h", bus.PC, 32'h200); end
    n_checks++;
    if (bus.mepc !== 32'h50) begin n_fail++; $display("FAIL both_mepc got=%h exp=%h", bus.mepc, 32'h50); end
    n_checks++;
    if (bus.in_trap !== 1'b1) begin n_fail++; $display("FAIL both_in_trap got=%b exp=1", bus.in_trap); end
    goto_pc(32'hFFFF_FFFC);
    tick();
    n_checks++;
    if (bus.PC !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got=%h exp=%h", bus.PC, 32'h0); end
    // mret from outside a handler still returns to mepc
    bus.mret = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.PC !== 32'h50) begin n_fail++; $display("FAIL mret_idle_pc got=%h exp=%h", bus.PC, 32'h50); end
    n_checks++;
    if (bus.in_trap !== 1'b0) begin n_fail++; $display("FAIL mret_idle_in_trap got=%b exp=0", bus.in_trap); end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.stall       = ($urandom_range(0, 3) == 0);
      bus.PCsrc       = 2'($urandom_range(0, 3));
      bus.ImmOp       = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) - 32'd128 : $urandom;
      bus.ALUResult   = $urandom;
      bus.trap        = ($urandom_range(0, 9) == 0);
      bus.mret        = ($urandom_range(0, 7) == 0);
      bus.mtvec_we    = ($urandom_range(0, 9) == 0);
      bus.mtvec_wdata = $urandom;
      tick();
      n_checks++;
      if (bus.PC !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, bus.PC, m_pc); end
      n_checks++;
      if (bus.PCPlus4 !== m_pc + 32'd4) begin n_fail++; $display("FAIL rnd_pcplus4[%0d] got=%h exp=%h", i, bus.PCPlus4, m_pc + 32'd4); end
      n_checks++;
      if (bus.mepc !== m_mepc) begin n_fail++; $display("FAIL rnd_mepc[%0d] got=%h exp=%h", i, bus.mepc, m_mepc); end
      n_checks++;
      if (bus.mtvec !== m_mtvec) begin n_fail++; $display("FAIL rnd_mtvec[%0d] got=%h exp=%h", i, bus.mtvec, m_mtvec); end
      n_checks++;
      if (bus.in_trap !== m_in_trap) begin n_fail++; $display("FAIL rnd_in_trap[%0d] got=%b exp=%b", i, bus.in_trap, m_in_trap); end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    goto_pc(32'h60);
    bus.trap        = 1'b1;
    tick();
    idle_inputs();
    bus.mtvec_we    = 1'b1;
    bus.mtvec_wdata = 32'h480;
    tick();
    idle_inputs();
    bus.stall = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.PC !== 32'h0) begin n_fail++; $display("FAIL async_pc got=%h exp=%h", bus.PC, 32'h0); end
    n_checks++;
    if (bus.mepc !== 32'h0) begin n_fail++; $display("FAIL async_mepc got=%h exp=%h", bus.mepc, 32'h0); end
    n_checks++;
    if (bus.mtvec !== 32'h100) begin n_fail++; $display("FAIL async_mtvec got=%h exp=%h", bus.mtvec, 32'h100); end
    n_checks++;
    if (bus.in_trap !== 1'b0) begin n_fail++; $display("FAIL async_in_trap got=%b exp=0", bus.in_trap); end
    n_checks++;
    if (bus.pc_valid !== 1'b0) begin n_fail++; $display("FAIL async_pc_valid got=%b exp=0", bus.pc_valid); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // First post-reset edge ignores trap/PCsrc
    idle_inputs();
    bus.trap      = 1'b1;
    bus.PCsrc     = 2'b10;
    bus.ALUResult = 32'h1234;
    tick();
    idle_inputs();
    n_checks++;
    if (bus.PC !== 32'h0) begin n_fail++; $display("FAIL first_edge_pc got=%h exp=%h", bus.PC, 32'h0); end
    n_checks++;
    if (bus.in_trap !== 1'b0) begin n_fail++; $display("FAIL first_edge_in_trap got=%b exp=0", bus.in_trap); end
    n_checks++;
    if (bus.pc_valid !== 1'b1) begin n_fail++; $display("FAIL first_edge_pc_valid got=%b exp=1", bus.pc_valid); end
    tick();
    n_checks++;
    if (bus.PC !== 32'h4) begin n_fail++; $display("FAIL post_reset_pc got=%h exp=%h", bus.PC, 32'h4); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    model_reset();
    idle_inputs();
    test_reset();
    test_sequential();
    test_branch();
    test_stall_trap();
    test_mtvec();
    test_trap_mret_wrap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
